// File: rtl/reg_writeback_unit.sv
// Register-bank write initiator: load extension, ordered {dest,data} queue, one write per cycle.
// Optional REG_WB_BYPASS_EN adds youngest-pending-value bypass for the queried register.
module reg_writeback_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        aluValid,
  input  logic [4:0]  aluDest,
  input  logic [31:0] aluData,
  output logic        aluReady,
  input  logic        memValid,
  input  logic [4:0]  memDest,
  input  logic [31:0] memData,
  input  logic [2:0]  memFunct,
  input  logic [1:0]  memByteOff,
  output logic        memReady,
  input  logic        wrStall,
  output logic [31:0] wrData,
  output logic [4:0]  wAddr,
  output logic        regWriteFlag,
  input  logic [4:0]  chkAddr,
  output logic        hazardHit,
  output logic        bypassValid,
  output logic [31:0] bypassData
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [4:0]    q_dest [DEPTH];
  logic [31:0]   q_data [DEPTH];

  logic          mem_live;
  logic          mem_push;
  logic          alu_push;
  logic          pop;
  logic [AW-1:0] alu_slot;
  logic [7:0]    mem_byte;
  logic [15:0]   mem_half;
  logic [31:0]   mem_ext;

  // Load extension
  always_comb begin
    mem_byte = memData[{memByteOff, 3'b000} +: 8];
    mem_half = memByteOff[1] ? memData[31:16] : memData[15:0];
    case (memFunct)
      3'b000:  mem_ext = {{24{mem_byte[7]}}, mem_byte};
      3'b001:  mem_ext = {{16{mem_half[15]}}, mem_half};
      3'b100:  mem_ext = {24'h0, mem_byte};
      3'b101:  mem_ext = {16'h0, mem_half};
      default: mem_ext = memData;
    endcase
  end

  // Readiness looks only at the registered count; a same-edge pop frees no slot.
  always_comb begin
    mem_live = memValid && (memDest != '0);
    memReady = (count < DEPTH_C) || (memDest == '0);
    aluReady = (count < (DEPTH_C - CW'(mem_live))) || (aluDest == '0);
    mem_push = mem_live && memReady;
    alu_push = aluValid && (aluDest != '0) && aluReady;
    pop      = !wrStall && (count != '0);
    alu_slot = mem_push ? (wr_ptr + AW'(1)) : wr_ptr;
  end

  // Queue storage needs no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      q_dest[wr_ptr] <= memDest;
      q_data[wr_ptr] <= mem_ext;
    end
    if (alu_push) begin
      q_dest[alu_slot] <= aluDest;
      q_data[alu_slot] <= aluData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wrData       <= '0;
      wAddr        <= '0;
      regWriteFlag <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(mem_push) + AW'(alu_push);
      count  <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
      if (pop) begin
        wrData       <= q_data[rd_ptr];
        wAddr        <= q_dest[rd_ptr];
        regWriteFlag <= 1'b1;
        rd_ptr       <= rd_ptr + AW'(1);
      end else begin
        regWriteFlag <= 1'b0;
      end
    end
  end

  // Hazard scan walks oldest to youngest so the last match is the newest value.
  always_comb begin
    logic          hit;
    logic [AW-1:0] idx;
`ifdef REG_WB_BYPASS_EN
    logic [31:0]   sel;
    sel = (regWriteFlag && (wAddr == chkAddr)) ? wrData : '0;
`endif
    hit = regWriteFlag && (wAddr == chkAddr);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + AW'(k);
      if ((CW'(k) < count) && (q_dest[idx] == chkAddr)) begin
        hit = 1'b1;
`ifdef REG_WB_BYPASS_EN
        sel = q_data[idx];
`endif
      end
    end
    hazardHit = hit && (chkAddr != '0);
`ifdef REG_WB_BYPASS_EN
    bypassValid = hazardHit;
    bypassData  = hazardHit ? sel : '0;
`else
    bypassValid = 1'b0;
    bypassData  = '0;
`endif
  end

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Self-checking bench for reg_writeback_unit: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_reg_writeback_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aluValid, memValid, wrStall;
  logic [4:0]  aluDest, memDest, chkAddr;
  logic [31:0] aluData, memData;
  logic [2:0]  memFunct;
  logic [1:0]  memByteOff;
  logic        aluReady, memReady, regWriteFlag, hazardHit, bypassValid;
  logic [31:0] wrData, bypassData;
  logic [4:0]  wAddr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_wdata;
  logic [4:0]  m_waddr;
  logic        m_flag;

  reg_writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady),
    .memValid(memValid), .memDest(memDest), .memData(memData), .memFunct(memFunct),
    .memByteOff(memByteOff), .memReady(memReady),
    .wrStall(wrStall), .wrData(wrData), .wAddr(wAddr), .regWriteFlag(regWriteFlag),
    .chkAddr(chkAddr), .hazardHit(hazardHit),
    .bypassValid(bypassValid), .bypassData(bypassData)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ext_load(input logic [31:0] w, input logic [2:0] f,
                                           input logic [1:0] off);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> (8 * off);
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (f)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                      input logic [2:0] mf, input logic [1:0] mo,
                      input logic av, input logic [4:0] ad, input logic [31:0] adat,
                      input logic st, input logic [4:0] ca);
    int          cnt;
    logic        er_m, er_a, hz;
    logic [31:0] byp;
    ent_t        e;
    @(negedge clk);
    memValid = mv; memDest = md; memData = mdat; memFunct = mf; memByteOff = mo;
    aluValid = av; aluDest = ad; aluData = adat; wrStall = st; chkAddr = ca;
    #1;
    cnt  = q.size();
    er_m = (cnt < DEPTH) || (md == 0);
    er_a = (cnt < DEPTH - ((mv && md != 0) ? 1 : 0)) || (ad == 0);
    hz   = 1'b0;
    byp  = '0;
    if (ca != 0) begin
      if (m_flag && m_waddr == ca) begin hz = 1'b1; byp = m_wdata; end
      foreach (q[i]) if (q[i].dest == ca) begin hz = 1'b1; byp = q[i].data; end
    end
    chk("memReady", 32'(memReady), 32'(er_m));
    chk("aluReady", 32'(aluReady), 32'(er_a));
    chk("hazardHit", 32'(hazardHit), 32'(hz));
`ifdef REG_WB_BYPASS_EN
    chk("bypassValid", 32'(bypassValid), 32'(hz));
    chk("bypassData", bypassData, byp);
`else
    chk("bypassValid", 32'(bypassValid), 32'd0);
    chk("bypassData", bypassData, 32'd0);
`endif
    @(posedge clk);
    if (!st && q.size() > 0) begin
      e = q.pop_front();
      m_wdata = e.data; m_waddr = e.dest; m_flag = 1'b1;
    end else begin
      m_flag = 1'b0;
    end
    if (mv && er_m && md != 0) q.push_back('{md, ext_load(mdat, mf, mo)});
    if (av && er_a && ad != 0) q.push_back('{ad, adat});
    #1;
    chk("regWriteFlag", 32'(regWriteFlag), 32'(m_flag));
    chk("wAddr", 32'(wAddr), 32'(m_waddr));
    chk("wrData", wrData, m_wdata);
  endtask

  task automatic idle(input logic st, input logic [4:0] ca);
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0, st, ca);
  endtask

  task automatic load(input logic [4:0] d, input logic [31:0] w, input logic [2:0] f,
                      input logic [1:0] o);
    step(1'b1, d, w, f, o, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic alu(input logic [4:0] d, input logic [31:0] v, input logic st);
    step(1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b1, d, v, st, 5'd0);
  endtask

  task automatic model_reset();
    q.delete();
    m_wdata = '0; m_waddr = '0; m_flag = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    aluValid = 0; aluDest = 0; aluData = 0; memValid = 0; memDest = 0; memData = 0;
    memFunct = 0; memByteOff = 0; wrStall = 0; chkAddr = 0;
    model_reset();
    #12;
    chk("rst_wrData", wrData, 32'd0);
    chk("rst_wAddr", 32'(wAddr), 32'd0);
    chk("rst_flag", 32'(regWriteFlag), 32'd0);
    chk("rst_memReady", 32'(memReady), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write latency
    alu(5'd5, 32'h1234, 1'b0);
    chk("lat_flag_early", 32'(regWriteFlag), 32'd0);
    idle(1'b0, 5'd0);
    chk("lat_flag", 32'(regWriteFlag), 32'd1);
    chk("lat_wAddr", 32'(wAddr), 32'd5);
    chk("lat_wrData", wrData, 32'h1234);
    idle(1'b0, 5'd0);
    chk("lat_flag_drop", 32'(regWriteFlag), 32'd0);

    // Load extension
    load(5'd1, 32'h80FF_7F01, 3'b000, 2'd3); idle(1'b0, 5'd0);
    chk("lb_off3", wrData, 32'hFFFF_FF80);
    load(5'd1, 32'h80FF_7F01, 3'b100, 2'd3); idle(1'b0, 5'd0);
    chk("lbu_off3", wrData, 32'h0000_0080);
    load(5'd1, 32'h80FF_7F01, 3'b001, 2'd2); idle(1'b0, 5'd0);
    chk("lh_off2", wrData, 32'hFFFF_80FF);
    load(5'd1, 32'h80FF_7F01, 3'b101, 2'd0); idle(1'b0, 5'd0);
    chk("lhu_off0", wrData, 32'h0000_7F01);
    load(5'd1, 32'h80FF_7F01, 3'b111, 2'd1); idle(1'b0, 5'd0);
    chk("funct7_lw", wrData, 32'h80FF_7F01);

    // Same-edge push: mem entry first
    step(1'b1, 5'd3, 32'hA, 3'b010, 2'd0, 1'b1, 5'd4, 32'hB, 1'b0, 5'd0);
    idle(1'b0, 5'd0);
    chk("order_first", 32'(wAddr), 32'd3);
    idle(1'b0, 5'd0);
    chk("order_second", 32'(wAddr), 32'd4);
    chk("order_second_data", wrData, 32'hB);
    idle(1'b0, 5'd0);

    // Fill under stall, $0 writes still handshaken
    for (int i = 0; i < DEPTH; i++) alu(5'(10 + i), 32'(100 + i), 1'b1);
    step(1'b1, 5'd0, 32'h55, 3'd2, 2'd0, 1'b1, 5'd0, 32'h66, 1'b1, 5'd12);
    chk("full_zero_memReady", 32'(memReady), 32'd1);
    step(1'b1, 5'd9, 32'h1, 3'd2, 2'd0, 1'b1, 5'd9, 32'h2, 1'b1, 5'd0);
    chk("full_memReady", 32'(memReady), 32'd0);
    chk("full_aluReady", 32'(aluReady), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      idle(1'b0, 5'd0);
      chk("drain_addr", 32'(wAddr), 32'(10 + i));
    end
    idle(1'b0, 5'd0);
    chk("drain_done", 32'(regWriteFlag), 32'd0);

    // Hazard with repeated destination
    alu(5'd7, 32'd1, 1'b1);
    alu(5'd7, 32'd2, 1'b1);
    idle(1'b1, 5'd7);
    chk("hazard_7", 32'(hazardHit), 32'd1);
    idle(1'b1, 5'd0);
    chk("hazard_0", 32'(hazardHit), 32'd0);
    for (int i = 0; i < 3; i++) idle(1'b0, 5'd7);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b0, 5'd0);

    // Reset in the middle of a drain
    for (int i = 0; i < 3; i++) alu(5'(20 + i), 32'(200 + i), 1'b1);
    idle(1'b0, 5'd20);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_flag", 32'(regWriteFlag), 32'd0);
    chk("mid_rst_wAddr", 32'(wAddr), 32'd0);
    chk("mid_rst_wrData", wrData, 32'd0);
    chkAddr = 5'd21;
    #1;
    chk("mid_rst_hazard", 32'(hazardHit), 32'd0);
    @(posedge clk); #1;
    chk("in_rst_flag", 32'(regWriteFlag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) idle(1'b0, 5'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
